// File: rtl/parking_gate_sequencer.sv
// Single-lane car park barrier sequencer: debounces the entry/exit sensors, arbitrates the shared gate,
// runs the open/wait-for-pass/close handshake with the servo and tracks lot occupancy.
module parking_gate_sequencer #(
  parameter int CAPACITY        = 8,
  parameter int CNT_W           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int PASS_TIMEOUT    = 250000000,
  parameter int SETTLE_CYCLES   = 4,
  parameter int TMR_W           = 28
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_entry_sensor,
  input  logic             i_exit_sensor,
  input  logic             i_done_moving,
  output logic             o_gate_trigger,
  output logic [CNT_W-1:0] o_occupancy,
  output logic             o_lot_full,
  output logic             o_busy,
  output logic             o_serving_exit,
  output logic             o_timeout_pulse
);

  localparam logic [TMR_W-1:0] DB_LAST   = TMR_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] PASS_LAST = TMR_W'(PASS_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] SETTLE    = TMR_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CAP       = CNT_W'(CAPACITY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_OPENING,
    S_WAIT_PASS,
    S_CLOSING
  } state_t;

  state_t           r_state;
  state_t           w_stateNext;
  logic [1:0]       w_raw;
  logic [1:0]       r_sync0;
  logic [1:0]       r_sync1;
  logic [1:0]       r_db;
  logic [TMR_W-1:0] r_dbCnt [2];
  logic [1:0]       w_dbFlip;
  logic [1:0]       w_rise;
  logic [1:0]       w_fall;
  logic             r_pendEntry;
  logic             r_pendExit;
  logic             w_eligEntry;
  logic             w_eligExit;
  logic             w_acceptEntry;
  logic             w_acceptExit;
  logic             w_dropExit;
  logic             w_servedFall;
  logic             w_timeout;
  logic [TMR_W-1:0] r_tmr;
  logic [TMR_W-1:0] w_tmrNext;
  logic [CNT_W-1:0] r_occ;
  logic [CNT_W-1:0] w_occNext;
  logic             r_lotFull;
  logic             r_gate;
  logic             r_servingExit;
  logic             r_timeoutPulse;

  // Index 0 is the entry lane, index 1 the exit lane.
  assign w_raw = {i_exit_sensor, i_entry_sensor};

  always_comb begin
    w_dbFlip = '0;
    for (int i = 0; i < 2; i++) begin
      w_dbFlip[i] = (r_sync1[i] != r_db[i]) && (r_dbCnt[i] == DB_LAST);
    end
  end

  assign w_rise = w_dbFlip & r_sync1;
  assign w_fall = w_dbFlip & ~r_sync1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync0 <= '0;
      r_sync1 <= '0;
      r_db    <= '0;
      for (int i = 0; i < 2; i++) begin
        r_dbCnt[i] <= '0;
      end
    end else begin
      r_sync0 <= w_raw;
      r_sync1 <= r_sync0;
      for (int i = 0; i < 2; i++) begin
        if (r_sync1[i] == r_db[i]) begin
          r_dbCnt[i] <= '0;
        end else if (w_dbFlip[i]) begin
          r_db[i]    <= r_sync1[i];
          r_dbCnt[i] <= '0;
        end else begin
          r_dbCnt[i] <= r_dbCnt[i] + TMR_W'(1);
        end
      end
    end
  end

  // A fresh rise wins over a same-cycle clear so no car is ever lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pendEntry <= 1'b0;
      r_pendExit  <= 1'b0;
    end else begin
      if (w_rise[0]) begin
        r_pendEntry <= 1'b1;
      end else if (w_acceptEntry) begin
        r_pendEntry <= 1'b0;
      end
      if (w_rise[1]) begin
        r_pendExit <= 1'b1;
      end else if (w_acceptExit || w_dropExit) begin
        r_pendExit <= 1'b0;
      end
    end
  end

  assign w_eligEntry  = r_pendEntry && !r_lotFull;
  assign w_eligExit   = r_pendExit && (r_occ != '0);
  assign w_servedFall = r_servingExit ? w_fall[1] : w_fall[0];

  // On a tie the last-served direction yields; serving_exit resets to 0, so exit wins first.
  always_comb begin
    w_stateNext   = r_state;
    w_tmrNext     = r_tmr;
    w_occNext     = r_occ;
    w_timeout     = 1'b0;
    w_acceptEntry = 1'b0;
    w_acceptExit  = 1'b0;
    w_dropExit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tmrNext  = '0;
        w_dropExit = r_pendExit && (r_occ == '0);
        if (w_eligExit && (!w_eligEntry || !r_servingExit)) begin
          w_acceptExit = 1'b1;
          w_stateNext  = S_OPENING;
        end else if (w_eligEntry) begin
          w_acceptEntry = 1'b1;
          w_stateNext   = S_OPENING;
        end
      end
      S_OPENING: begin
        if (r_tmr < SETTLE) begin
          w_tmrNext = r_tmr + TMR_W'(1);
        end else if (i_done_moving) begin
          w_tmrNext   = '0;
          w_stateNext = S_WAIT_PASS;
        end
      end
      S_WAIT_PASS: begin
        if (w_servedFall) begin
          w_tmrNext   = '0;
          w_stateNext = S_CLOSING;
          if (r_servingExit) begin
            w_occNext = (r_occ != '0) ? r_occ - CNT_W'(1) : r_occ;
          end else begin
            w_occNext = (r_occ < CAP) ? r_occ + CNT_W'(1) : r_occ;
          end
        end else if (r_tmr == PASS_LAST) begin
          w_tmrNext   = '0;
          w_timeout   = 1'b1;
          w_stateNext = S_CLOSING;
        end else begin
          w_tmrNext = r_tmr + TMR_W'(1);
        end
      end
      S_CLOSING: begin
        if (r_tmr < SETTLE) begin
          w_tmrNext = r_tmr + TMR_W'(1);
        end else if (i_done_moving) begin
          w_tmrNext   = '0;
          w_stateNext = S_IDLE;
        end
      end
      default: begin
        w_tmrNext   = '0;
        w_stateNext = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_tmr          <= '0;
      r_occ          <= '0;
      r_lotFull      <= 1'b0;
      r_gate         <= 1'b0;
      r_servingExit  <= 1'b0;
      r_timeoutPulse <= 1'b0;
    end else begin
      r_state        <= w_stateNext;
      r_tmr          <= w_tmrNext;
      r_occ          <= w_occNext;
      r_lotFull      <= (w_occNext == CAP);
      r_gate         <= (w_stateNext == S_OPENING) || (w_stateNext == S_WAIT_PASS);
      r_timeoutPulse <= w_timeout;
      if (w_acceptExit) begin
        r_servingExit <= 1'b1;
      end else if (w_acceptEntry) begin
        r_servingExit <= 1'b0;
      end
    end
  end

  assign o_gate_trigger  = r_gate;
  assign o_occupancy     = r_occ;
  assign o_lot_full      = r_lotFull;
  assign o_busy          = (r_state != S_IDLE);
  assign o_serving_exit  = r_servingExit;
  assign o_timeout_pulse = r_timeoutPulse;

endmodule

// File: doc/parking_gate_sequencer.md
Name: parking_gate_sequencer

Overview:
Single-lane barrier sequencer for the car park. It debounces the entry and exit vehicle sensors and arbitrates between them for the one shared gate. It drives the servo controller's gate_trigger and sequences open -> wait-for-pass -> close using the servo's done_moving handshake. It maintains lot occupancy and a full flag for the display logic.

Parameters:
CAPACITY, 8, number of spaces; entry is refused while occupancy equals CAPACITY
CNT_W, 4, occupancy width; must satisfy 2^CNT_W > CAPACITY
DEBOUNCE_CYCLES, 500000, cycles a synchronized sensor level must hold before it is accepted (10 ms at 50 MHz)
PASS_TIMEOUT, 250000000, maximum cycles in WAIT_PASS before a forced close (5 s)
SETTLE_CYCLES, 4, cycles after any gate_trigger change during which done_moving is ignored
TMR_W, 28, width of the shared debounce, pass and settle timers; must hold PASS_TIMEOUT

Ports:
clk  in  1  system clock; the only clock
rst_n  in  1  asynchronous, active-low reset
entry_sensor  in  1  raw entry-lane vehicle detector; high = car present
exit_sensor  in  1  raw exit-lane vehicle detector; high = car present
done_moving  in  1  from the servo controller; high = servo settled at the commanded position
gate_trigger  out  1  to the servo controller; 1 = open, 0 = closed
occupancy  out  CNT_W  cars currently in the lot
lot_full  out  1  high when occupancy == CAPACITY
busy  out  1  high in any state other than IDLE
serving_exit  out  1  direction of the current or last cycle; 1 = exit, 0 = entry
timeout_pulse  out  1  one-cycle pulse when WAIT_PASS expires

Behaviour:
- Reset values: gate_trigger=0, occupancy=0, lot_full=0, busy=0, serving_exit=0, timeout_pulse=0, state=IDLE, pending flags=0, priority=exit-first. Reset may assert in any state; gate_trigger drops to 0 asynchronously and the servo closes on its own.
- Sensor path: 2-FF synchronizer per sensor, then a per-sensor debounce counter. The debounced level changes only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles. A mismatch that ends early clears the counter.
- A debounced rising edge sets pending_entry or pending_exit. These flags stay set until accepted. Edges that arrive in any state are captured.
- pending_exit with occupancy==0: the flag is dropped when seen in IDLE (phantom exit). occupancy never underflows.
- pending_entry with lot_full=1: the flag is held, not served, and stays pending until a space frees.
- Arbitration in IDLE: among eligible requests, a single request wins. If both are eligible, the direction not served last wins. After reset the first tie goes to exit. The accepted flag clears on the acceptance cycle, and serving_exit latches the winner.
- FSM:
  - IDLE: an eligible request moves to OPENING on the next clk edge and sets gate_trigger=1.
  - OPENING: wait SETTLE_CYCLES, then wait for done_moving=1, then go to WAIT_PASS. There is no timeout.
  - WAIT_PASS: clears the pass timer on entry. A debounced falling edge of the served sensor means the car has passed. In that case occupancy increments (entry) or decrements (exit) in the same cycle, and the FSM goes to CLOSING.
  - WAIT_PASS timeout: if the timer reaches PASS_TIMEOUT, timeout_pulse=1 for one cycle, occupancy is unchanged, and the FSM goes to CLOSING.
  - CLOSING: gate_trigger=0, wait SETTLE_CYCLES, then wait for done_moving=1, then return to IDLE.
- Servo handshake: done_moving lags a gate_trigger change by up to one servo step period, so it is ignored during the settle window.
- Sensor activity on the non-served lane during a cycle only sets its pending flag. It never alters the FSM or occupancy.
- Occupancy arithmetic: unsigned CNT_W bits. It saturates at 0 and at CAPACITY, and never wraps.
- lot_full is registered from the next-state occupancy, so it is valid in the same cycle as occupancy.
- Latency: from a raw sensor rise, gate_trigger rises after 2 + DEBOUNCE_CYCLES + 2 cycles, ±1.

Test Plan:
(Bench parameters: CAPACITY=2, DEBOUNCE_CYCLES=4, PASS_TIMEOUT=100, SETTLE_CYCLES=4. done_moving is modelled as 0 for 10 cycles after each gate_trigger change, then 1.)
- Entry, empty lot: entry_sensor high 20 cycles, then low -> gate_trigger=1 about 8 cycles after the rise; occupancy 0->1 on the debounced fall; gate_trigger=0; busy drops after the close handshake; timeout_pulse never asserts.
- Glitch: entry_sensor high for 3 cycles only -> no pending flag, gate_trigger stays 0, occupancy stays 0.
- Full lot: two entries -> occupancy=2, lot_full=1. A third entry stays pending and gate_trigger stays 0. An exit cycle then runs and gives occupancy=1, lot_full=0. The pending entry is then served automatically, giving occupancy=2.
- Simultaneous requests, fresh reset: entry and exit rise together with occupancy=1 -> exit served first (serving_exit=1, occupancy 1->0). Entry served next (occupancy 0->1).
- Timeout: entry_sensor held high indefinitely -> timeout_pulse for exactly 1 cycle, 100 cycles after WAIT_PASS entry; gate closes; occupancy unchanged.
- Phantom exit and reset: exit rise with occupancy=0 -> flag dropped, gate_trigger stays 0. Assert rst_n=0 during OPENING -> gate_trigger=0 immediately; all outputs at reset values.
